audio_avg_filter: RTL and testbench

AUDIO_AVG_FILTER -- requirements
Module: audio_avg_filter

---
 rtl/audio_avg_filter.sv | 126 ++++++++++++
 tb/tb_audio_avg_filter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_avg_filter.sv
// rtl/audio_avg_filter.sv - stereo moving-average filter between codec FIFOs; optional bypass under AUDIO_FILTER_BYPASS_EN
module audio_avg_filter #(
  parameter int DATA_W     = 24,
  parameter int LOG2_DEPTH = 3
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  input  logic              write_ready,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right
`ifdef AUDIO_FILTER_BYPASS_EN
  ,
  input  logic              bypass
`endif
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int ACC_W = DATA_W + LOG2_DEPTH;
  // A window of one still needs a one-bit pointer to have a legal vector.
  localparam int PTR_W = (LOG2_DEPTH == 0) ? 1 : LOG2_DEPTH;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    WAIT_WR = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [DATA_W-1:0] sample_left;
  logic signed [DATA_W-1:0] sample_right;
  logic signed [DATA_W-1:0] line_left  [DEPTH];
  logic signed [DATA_W-1:0] line_right [DEPTH];
  logic signed [ACC_W-1:0]  sum_left;
  logic signed [ACC_W-1:0]  sum_right;
  logic signed [ACC_W-1:0]  sum_left_next;
  logic signed [ACC_W-1:0]  sum_right_next;
  logic [PTR_W-1:0]         wr_ptr;

  // State register: the only control state in the block.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: pop in IDLE, one compute cycle, then hold until the codec takes the result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (read_ready)  state_next = CALC;
      CALC:    state_next = WAIT_WR;
      WAIT_WR: if (write_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are combinational so the pop/push lands in the same cycle the codec flags ready;
  // gating with resetn keeps both low on any edge that is resetting the block.
  always_comb begin
    read  = 1'b0;
    write = 1'b0;
    if (resetn) begin
      read  = (state == IDLE)    && read_ready;
      write = (state == WAIT_WR) && write_ready;
    end
  end

  // Running sum update: add the newest sample, drop the one leaving the window.
  always_comb begin
    sum_left_next  = sum_left  + ACC_W'(sample_left)  - ACC_W'(line_left[wr_ptr]);
    sum_right_next = sum_right + ACC_W'(sample_right) - ACC_W'(line_right[wr_ptr]);
  end

  // Datapath: capture on pop, update history and output registers in CALC only.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      sample_left     <= '0;
      sample_right    <= '0;
      sum_left        <= '0;
      sum_right       <= '0;
      wr_ptr          <= '0;
      writedata_left  <= '0;
      writedata_right <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        line_left[i]  <= '0;
        line_right[i] <= '0;
      end
    end else begin
      if (read) begin
        sample_left  <= readdata_left;
        sample_right <= readdata_right;
      end
      if (state == CALC) begin
        line_left[wr_ptr]  <= sample_left;
        line_right[wr_ptr] <= sample_right;
        sum_left           <= sum_left_next;
        sum_right          <= sum_right_next;
        wr_ptr             <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
`ifdef AUDIO_FILTER_BYPASS_EN
        // History keeps updating in bypass so the average is seamless when bypass drops.
        if (bypass) begin
          writedata_left  <= sample_left;
          writedata_right <= sample_right;
        end else begin
          writedata_left  <= DATA_W'(sum_left_next  >>> LOG2_DEPTH);
          writedata_right <= DATA_W'(sum_right_next >>> LOG2_DEPTH);
        end
`else
        writedata_left  <= DATA_W'(sum_left_next  >>> LOG2_DEPTH);
        writedata_right <= DATA_W'(sum_right_next >>> LOG2_DEPTH);
`endif
      end
    end
  end

endmodule

// File: tb/tb_audio_avg_filter.sv
// tb/tb_audio_avg_filter.sv - scoreboard bench for audio_avg_filter against a windowed-mean model
module tb_audio_avg_filter;

  localparam int DW    = 24;
  localparam int L2    = 2;
  localparam int DEPTH = 1 << L2;

  logic                 CLOCK_50   = 1'b0;
  logic                 resetn     = 1'b0;
  logic                 read_ready = 1'b0;
  logic signed [DW-1:0] rd_l       = '0;
  logic signed [DW-1:0] rd_r       = '0;
  logic                 read;
  logic                 write;
  logic signed [DW-1:0] wd_l;
  logic signed [DW-1:0] wd_r;
  logic                 wr_fixed = 1'b0;
  logic                 wr_rand  = 1'b0;
  logic                 rand_wr  = 1'b0;
  logic                 write_ready;
`ifdef AUDIO_FILTER_BYPASS_EN
  logic                 bypass = 1'b0;
`endif

  assign write_ready = rand_wr ? wr_rand : wr_fixed;

  int checks   = 0;
  int passes   = 0;
  int cyc      = 0;
  int n_reads  = 0;
  int n_writes = 0;
  int exp_l[$];
  int exp_r[$];
  int tbl_l[$];
  int tbl_r[$];
  int hist_l[$];
  int hist_r[$];
  int read_cyc_q[$];
  bit lat_check = 1'b0;
  bit thr_check = 1'b0;
  int last_read = -1;
  logic [1:0]           rd_hist   = '0;
  logic [1:0]           rst_hist  = '0;
  logic signed [DW-1:0] prev_wd_l = '0;
  logic signed [DW-1:0] prev_wd_r = '0;

  audio_avg_filter #(.DATA_W(DW), .LOG2_DEPTH(L2)) dut (
    .CLOCK_50        (CLOCK_50),
    .resetn          (resetn),
    .read_ready      (read_ready),
    .readdata_left   (rd_l),
    .readdata_right  (rd_r),
    .read            (read),
    .write_ready     (write_ready),
    .write           (write),
    .writedata_left  (wd_l),
    .writedata_right (wd_r)
`ifdef AUDIO_FILTER_BYPASS_EN
    ,
    .bypass          (bypass)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    cyc <= cyc + 1;
    #1;
    wr_rand = 1'($urandom_range(0, 1));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d passed of %0d", passes, checks);
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int floor_div(input longint a, input int b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return int'(q);
  endfunction

  function automatic int window_mean(input int h[$]);
    longint s;
    s = 0;
    foreach (h[i]) s += h[i];
    return floor_div(s, DEPTH);
  endfunction

  // Stimulus side of the scoreboard: every accepted sample yields one expected output.
  always @(negedge CLOCK_50) begin : capture
    int el;
    int er;
    if (resetn && read) begin
      n_reads++;
      check("read_needs_ready", read_ready, 1);
      hist_l.push_back(int'(rd_l));
      hist_r.push_back(int'(rd_r));
      if (hist_l.size() > DEPTH) void'(hist_l.pop_front());
      if (hist_r.size() > DEPTH) void'(hist_r.pop_front());
      el = window_mean(hist_l);
      er = window_mean(hist_r);
`ifdef AUDIO_FILTER_BYPASS_EN
      if (bypass) begin
        el = int'(rd_l);
        er = int'(rd_r);
      end
`endif
      if (tbl_l.size() > 0) begin
        el = tbl_l.pop_front();
        er = tbl_r.pop_front();
      end
      exp_l.push_back(el);
      exp_r.push_back(er);
      if (lat_check) read_cyc_q.push_back(cyc);
      if (thr_check && last_read >= 0) check("read_interval", cyc - last_read, 3);
      last_read = cyc;
    end
  end

  // Output side: compare each pushed result and watch strobe/holding rules.
  always @(negedge CLOCK_50) begin : monitor
    if (resetn && write) begin
      n_writes++;
      check("write_needs_ready", write_ready, 1);
      check("no_read_with_write", read, 0);
      check("scoreboard_nonempty", int'(exp_l.size() > 0), 1);
      if (exp_l.size() > 0) begin
        check("left_out", int'(wd_l), exp_l.pop_front());
        check("right_out", int'(wd_r), exp_r.pop_front());
      end
      if (lat_check && read_cyc_q.size() > 0) check("latency", cyc - read_cyc_q.pop_front(), 2);
    end
    if (resetn && rst_hist == 2'b11 && (wd_l != prev_wd_l || wd_r != prev_wd_r))
      check("wd_change_after_calc", rd_hist[1], 1);
    rd_hist   = {rd_hist[0], resetn && read};
    rst_hist  = {rst_hist[0], resetn};
    prev_wd_l = wd_l;
    prev_wd_r = wd_r;
  end

  task automatic do_reset();
    @(posedge CLOCK_50); #1;
    resetn     = 1'b0;
    read_ready = 1'b1;
    exp_l.delete(); exp_r.delete();
    tbl_l.delete(); tbl_r.delete();
    hist_l.delete(); hist_r.delete();
    read_cyc_q.delete();
    last_read = -1;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_wd_l", wd_l, 0);
    check("rst_wd_r", wd_r, 0);
    @(posedge CLOCK_50); #1;
    resetn     = 1'b1;
    read_ready = 1'b0;
  endtask

  task automatic send_sample(input int l, input int r, input bit rnd_rr);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    rd_l = DW'(l);
    rd_r = DW'(r);
    read_ready = 1'b1;
    while (!got && n < 100) begin
      @(negedge CLOCK_50);
      got = read;
      if (!got) begin
        @(posedge CLOCK_50); #1;
        if (rnd_rr) read_ready = 1'($urandom_range(0, 1));
        n++;
      end
    end
    check("read_strobe_seen", got, 1);
    @(posedge CLOCK_50); #1;
    @(posedge CLOCK_50); #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    read_ready = 1'b0;
    while (exp_l.size() > 0 && n < 300) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
    check("drain", exp_l.size(), 0);
  endtask

  initial begin
    logic signed [DW-1:0] tl;
    logic signed [DW-1:0] tr;
    int nw0;
    int nr0;

    do_reset();

    // Constant 1000 ramps up over the window, back-to-back with continuous read_ready.
    wr_fixed  = 1'b1;
    lat_check = 1'b1;
    thr_check = 1'b1;
    tbl_l = '{250, 500, 750, 1000, 1000, 1000};
    tbl_r = '{250, 500, 750, 1000, 1000, 1000};
    repeat (6) send_sample(1000, 1000, 1'b0);
    wait_drain();
    thr_check = 1'b0;

    // Impulse on left, constant negative on right.
    do_reset();
    tbl_l = '{100, 100, 100, 100, 0};
    tbl_r = '{-1, -2, -3, -4, -4};
    send_sample(400, -4, 1'b0);
    repeat (4) send_sample(0, -4, 1'b0);
    wait_drain();

    // Output back-pressure: nothing moves while write_ready is low.
    lat_check = 1'b0;
    wr_fixed  = 1'b0;
    send_sample(800, -800, 1'b0);
    nw0 = n_writes;
    nr0 = n_reads;
    repeat (10) @(posedge CLOCK_50);
    #1;
    check("hold_no_write", n_writes - nw0, 0);
    check("hold_no_read", n_reads - nr0, 0);
    rd_l = DW'(321);
    rd_r = DW'(-321);
    wr_fixed = 1'b1;
    @(negedge CLOCK_50);
    check("release_write", write, 1);
    @(posedge CLOCK_50); #1;
    @(negedge CLOCK_50);
    check("read_after_write", read, 1);
    @(posedge CLOCK_50); #1;
    read_ready = 1'b0;
    wait_drain();

    // Reset while waiting to write discards the sample and clears history.
    wr_fixed = 1'b0;
    send_sample(1234, -99, 1'b0);
    read_ready = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    nw0 = n_writes;
    do_reset();
    wr_fixed  = 1'b1;
    lat_check = 1'b1;
    tbl_l = '{250, 500, 750};
    tbl_r = '{250, 500, 750};
    repeat (3) send_sample(1000, 1000, 1'b0);
    wait_drain();
    check("writes_after_reset", n_writes - nw0, 3);
    lat_check = 1'b0;

`ifdef AUDIO_FILTER_BYPASS_EN
    do_reset();
    tbl_l = '{1000, 1000, 750, 1000};
    tbl_r = '{1000, 1000, 750, 1000};
    bypass = 1'b1;
    repeat (2) send_sample(1000, 1000, 1'b0);
    bypass = 1'b0;
    repeat (2) send_sample(1000, 1000, 1'b0);
    wait_drain();
`endif

    // Random full-range samples with random handshakes on both sides.
    rand_wr = 1'b1;
    for (int i = 0; i < 150; i++) begin
      tl = DW'($urandom);
      tr = DW'($urandom);
      send_sample(int'(tl), int'(tr), 1'b1);
    end
    wait_drain();
    rand_wr = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
